// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo counter family.
package counter_pkg;

    typedef enum logic {DOWN = 1'b0, UP = 1'b1} count_dir_t;
    typedef enum logic {SATURATE = 1'b0, WRAP = 1'b1} bound_mode_t;

    // Largest value a counter of the given modulus may hold.
    function automatic int unsigned max_count(input int unsigned modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/mod_step_unit.sv
// Combinational next-count and terminal-count computation for mod_counter.
module mod_step_unit
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 10
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] step,
    input  logic             up,
    input  logic             wrap,
    output logic [WIDTH-1:0] nxt,
    output logic             tc
);

    // One extra bit so Q+s and Q+MODULUS-s never overflow.
    localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(max_count(MODULUS));
    localparam logic [WIDTH:0] MOD_V = (WIDTH+1)'(MODULUS);

    logic [WIDTH:0] q_w;
    logic [WIDTH:0] s;
    logic [WIDTH:0] sum;

    always_comb begin
        q_w = {1'b0, q};
        s   = ({1'b0, step} > MAX_V) ? MAX_V : {1'b0, step};
        sum = q_w + s;
        nxt = q;
        tc  = 1'b0;
        if (count_dir_t'(up) == UP) begin
            if (sum <= MAX_V) begin
                nxt = WIDTH'(sum);
            end else begin
                tc  = 1'b1;
                nxt = (bound_mode_t'(wrap) == WRAP) ? WIDTH'(sum - MOD_V) : WIDTH'(MAX_V);
            end
        end else begin
            if (q_w >= s) begin
                nxt = WIDTH'(q_w - s);
            end else begin
                tc  = 1'b1;
                nxt = (bound_mode_t'(wrap) == WRAP) ? WIDTH'(q_w + MOD_V - s) : '0;
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with load, clear, wrap/saturate and terminal count.
// Optional compare output enabled by defining MOD_COUNTER_MATCH_EN.
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    input  logic             wrap,
`ifdef MOD_COUNTER_MATCH_EN
    input  logic [WIDTH-1:0] cmp,
    output logic             match,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("mod_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH:0]   MOD_V = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_count(MODULUS));

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] step_nxt;
    logic             step_tc;

    mod_step_unit #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .q    (q_q),
        .step (step),
        .up   (up),
        .wrap (wrap),
        .nxt  (step_nxt),
        .tc   (step_tc)
    );

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (clear) begin
            q_d = '0;
        end else if (en && load) begin
            q_d = ({1'b0, D} < MOD_V) ? D : MAX_Q;
        end else if (en) begin
            q_d  = step_nxt;
            tc_d = step_tc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

`ifdef MOD_COUNTER_MATCH_EN
    logic match_q, match_d;

    // Compare against next-Q so match lines up with the registered Q.
    always_comb begin
        match_d = (q_d == cmp);
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`endif

    assign Q      = q_q;
    assign tc     = tc_q;
    assign at_max = (q_q == MAX_Q);
    assign at_min = (q_q == '0);

endmodule
